// File: rtl/decoder_2x4_stream_pkg.sv
// decoder_2x4_stream_pkg: shared widths, disabled-output constant and one-hot decode helper
package decoder_2x4_stream_pkg;
    localparam int CODE_W = 2;
    localparam int OH_W = 4;
    localparam logic [OH_W-1:0] Y_OFF = '0;
    localparam logic [OH_W-1:0] Y_ONE = 4'b0001;
    function automatic logic [OH_W-1:0] decode_onehot(input logic en, input logic [CODE_W-1:0] code);
        return en ? Y_ONE << code : Y_OFF;
    endfunction
endpackage

// File: rtl/onehot_fifo2.sv
// onehot_fifo2: small registered FIFO holding decoded one-hot words; head is forced to zero when empty
module onehot_fifo2
    import decoder_2x4_stream_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [OH_W-1:0] din,
    input  logic            pop,
    output logic            in_ready,
    output logic            out_valid,
    output logic [OH_W-1:0] dout
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [OH_W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;
    assign in_ready = count < FULL;
    assign out_valid = count != '0;
    assign dout = out_valid ? mem[rd_ptr] : Y_OFF;
    assign do_push = push & in_ready;
    assign do_pop = pop & out_valid;
    // storage needs no reset: the head is masked by out_valid
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/decoder_2x4_stream.sv
// decoder_2x4_stream: streaming 2-to-4 one-hot decoder with output FIFO and saturating per-line hit counters
module decoder_2x4_stream
    import decoder_2x4_stream_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CODE_W-1:0] code_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OH_W-1:0]   y_out,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              clr_cnt,
    input  logic [1:0]        cnt_sel,
    output logic [CNT_W-1:0]  hit_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] cnt [4];
    logic [OH_W-1:0] y_dec;
    logic push;
    assign y_dec = decode_onehot(en, code_in);
    assign push = in_valid & in_ready;
    assign hit_cnt = cnt[cnt_sel];
    onehot_fifo2 #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .din       (y_dec),
        .pop       (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .dout      (y_out)
    );
    // clear wins over a same-edge increment; counters stick at all-ones
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        else if (clr_cnt)
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        else if (push && en && cnt[code_in] != CNT_MAX)
            cnt[code_in] <= cnt[code_in] + 1'b1;
endmodule

// File: tb/tb_decoder_2x4_stream.sv
// tb_decoder_2x4_stream: directed and random stimulus against a queue-based reference model, two counter widths
module tb_decoder_2x4_stream;
    logic clk = 1'b0;
    logic rst_n, en, in_valid, out_ready, clr_cnt;
    logic [1:0] code_in, cnt_sel;
    logic in_ready, out_valid, in_ready2, out_valid2;
    logic [3:0] y_out, y_out2;
    logic [7:0] hit8;
    logic [1:0] hit2;
    int n_chk = 0;
    int n_err = 0;
    logic [3:0] q[$];
    int c8[4];
    int c2[4];

    always #5 clk = ~clk;

    decoder_2x4_stream dut (
        .clk(clk), .rst_n(rst_n), .en(en), .code_in(code_in), .in_valid(in_valid),
        .in_ready(in_ready), .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready),
        .clr_cnt(clr_cnt), .cnt_sel(cnt_sel), .hit_cnt(hit8)
    );
    decoder_2x4_stream #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .code_in(code_in), .in_valid(in_valid),
        .in_ready(in_ready2), .y_out(y_out2), .out_valid(out_valid2), .out_ready(out_ready),
        .clr_cnt(clr_cnt), .cnt_sel(cnt_sel), .hit_cnt(hit2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("y_out", 32'(y_out), q.size() > 0 ? 32'(q[0]) : 32'd0);
        chk("in_ready_w2", 32'(in_ready2), 32'(q.size() < 2));
        chk("y_out_w2", 32'(y_out2), q.size() > 0 ? 32'(q[0]) : 32'd0);
        chk("hit_cnt8", 32'(hit8), 32'(c8[cnt_sel]));
        chk("hit_cnt2", 32'(hit2), 32'(c2[cnt_sel]));
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 4; i++) begin
            c8[i] = 0;
            c2[i] = 0;
        end
    endtask

    // drive one cycle from a negedge, advance the model at the posedge, check at the next negedge
    task automatic cycle(input logic v, input logic e, input logic [1:0] c,
                         input logic ordy, input logic clr, input logic [1:0] sel);
        bit acc, deq;
        in_valid = v;
        en = e;
        code_in = c;
        out_ready = ordy;
        clr_cnt = clr;
        cnt_sel = sel;
        acc = v && q.size() < 2;
        deq = ordy && q.size() > 0;
        @(posedge clk);
        if (deq) void'(q.pop_front());
        if (acc) q.push_back(e ? 4'(1 << c) : 4'd0);
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                c8[i] = 0;
                c2[i] = 0;
            end
        end else if (acc && e) begin
            c8[c] = (c8[c] < 255) ? c8[c] + 1 : 255;
            c2[c] = (c2[c] < 3) ? c2[c] + 1 : 3;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y_out", 32'(y_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
            chk("rst_hit8", 32'(hit8), 32'd0);
            chk("rst_hit2", 32'(hit2), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {en, in_valid, out_ready, clr_cnt} = '0;
        code_in = '0;
        cnt_sel = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 2'(i), 1, 0, 2'(i));
            chk("decode_seq", 32'(y_out), 32'(1 << i));
        end
        cycle(0, 1, 0, 1, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cycle(1, 1, 2, 0, 0, 2);
        chk("stall_head", 32'(y_out), 32'b0001);
        cycle(1, 1, 2, 1, 0, 2);
        chk("drain_first", 32'(y_out), 32'b0010);
        cycle(1, 1, 2, 1, 0, 2);
        chk("third_accepted", 32'(y_out), 32'b0100);
        cycle(0, 1, 0, 1, 0, 3);
        cycle(1, 0, 3, 1, 0, 3);
        chk("en0_y", 32'(y_out), 32'd0);
        chk("en0_valid", 32'(out_valid), 32'd1);
        chk("en0_cnt3", 32'(hit8), 32'd1);
        for (int i = 0; i < 5; i++) cycle(1, 1, 2, 1, 0, 2);
        chk("sat_hit2", 32'(hit2), 32'd3);
        cycle(1, 1, 2, 1, 1, 2);
        chk("clr_prio_hit2", 32'(hit2), 32'd0);
        chk("clr_prio_hit8", 32'(hit8), 32'd0);
        cycle(0, 1, 0, 1, 0, 0);
        cycle(1, 1, 1, 0, 0, 1);
        cycle(1, 1, 3, 1, 0, 3);
        chk("pushpop_valid", 32'(out_valid), 32'd1);
        chk("pushpop_ready", 32'(in_ready), 32'd1);
        chk("pushpop_head", 32'(y_out), 32'b1000);
        cycle(0, 1, 0, 1, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 1, 3, 0, 0, 3);
        chk("post_rst_accept", 32'(y_out), 32'b1000);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 2'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, 2'($urandom));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
